sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter STROBE_CYCLES, default 2, width of the OE/WE strobe phase in clk cycles (legal 1..15).
REQ-002 SHALL have ports:
- clk  in  1  clock, all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  grant enable; low blocks new grants, an access in progress completes.
- a_req, b_req  in  1  access request, port A / port B.
- a_we, b_we  in  1  1 = write, 0 = read.
- a_addr, b_addr  in  18  word address.
- a_wdata, b_wdata  in  16  write data.
- a_ack, b_ack  out  1  one-cycle completion pulse.
- a_rdata, b_rdata  out  16  last read data for that port.
- busy  out  1  high in any state except IDLE.
- ram_addr  out  18  SRAM address.
- ram_data  inout  16  SRAM data bus.
- ram_en_n, ram_oe_n, ram_we_n  out  1  SRAM chip enable, output enable and write enable, all active-low.

Function
REQ-003 SHALL implement the FSM IDLE -> SETUP -> STROBE -> DONE -> IDLE.
REQ-004 IDLE: strobes high, ram_data hi-Z. On an edge with en=1 and any req=1: pick a winner, latch its we/addr/wdata, go to SETUP.
REQ-005 Arbitration SHALL be round-robin.
- Single requester wins.
- When both request, the port not granted last wins.
- last_grant resets to B, so A wins the first tie.
REQ-006 SETUP (1 cycle):
- ram_en_n=0, ram_addr=latched addr.
- Write: ram_data driven with latched wdata, ram_we_n=1.
- Read: ram_data hi-Z, ram_oe_n=0.
REQ-007 STROBE (STROBE_CYCLES cycles, 4-bit down-counter): SETUP outputs held, plus ram_we_n=0 on a write.
REQ-008 On the edge leaving STROBE, a read SHALL capture ram_data into the granted port's rdata register.
REQ-009 DONE (1 cycle):
- ram_en_n=ram_oe_n=ram_we_n=1.
- Write: ram_data still driven (hold time). Read: ram_data hi-Z.
- Granted port's ack=1, Moore output of DONE.
REQ-010 Latency: with req sampled at edge k, ack SHALL be high from edge k+1+STROBE_CYCLES to k+2+STROBE_CYCLES. Throughput is one access per STROBE_CYCLES+3 cycles.
REQ-011 A req still high in the cycle after ack SHALL be treated as a new request.
REQ-012 A req dropped before ack SHALL NOT abort the access; it completes and acks normally.
REQ-013 Latched we/addr/wdata SHALL NOT change before DONE, regardless of input changes.
REQ-014 ram_data SHALL be driven only in SETUP/STROBE/DONE of a write; never driven while ram_oe_n=0.
REQ-015 a_rdata/b_rdata SHALL hold their value until that port's next read completes; writes leave them unchanged.
REQ-016 Only the granted port's ack SHALL pulse; a_ack and b_ack SHALL never be high together.

Reset
REQ-017 rst=0 SHALL force immediately, including mid-access:
- state=IDLE, counter=0, last_grant=B.
- ram_en_n=ram_oe_n=ram_we_n=1, ram_data hi-Z, ram_addr=0.
- a_ack=b_ack=0, busy=0, a_rdata=b_rdata=0.
REQ-018 An access interrupted by reset SHALL produce no ack after reset release.

Structure
REQ-019 Package sram_arb_pkg SHALL hold the FSM state encoding, STROBE_CYCLES default, and address/data width constants (18/16).
REQ-020 The two-way round-robin picker SHALL be a sub-module sram_arb_rr (inputs req pair, last_grant; output grant); all else in sram_arbiter.

Verification
REQ-021 A writes 0x1234 to 0x00010 (STROBE_CYCLES=2): ram_we_n low exactly 2 cycles, data driven SETUP..DONE, a_ack at edge k+3.
REQ-022 Read back 0x00010 on B, with the SRAM model returning 0x1234: b_rdata=0x1234 at b_ack, a_rdata unchanged.
REQ-023 a_req and b_req held high together for 4 accesses: grants A,B,A,B, each ack spaced 5 cycles.
REQ-024 en=0 with a_req=1 for 10 cycles: no grant, busy=0. en=1: SETUP on next edge.
REQ-025 rst asserted during STROBE of a write: strobes high and bus hi-Z same cycle, no ack after release, last_grant=B.
REQ-026 a_req pulsed 1 cycle only: access completes, single a_ack, FSM returns to IDLE.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// Covers the FSM state encoding, the port identifiers and the bus widths.
package sram_arb_pkg;

  localparam int ADDR_W            = 18;
  localparam int DATA_W            = 16;
  localparam int STROBE_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage

// File: rtl/sram_arb_rr.sv
// Two-way round-robin picker: a lone requester wins, and on a tie the port
// that was not granted last time wins.
module sram_arb_rr
  import sram_arb_pkg::*;
(
  input  logic [1:0] req,        // [0] = port A, [1] = port B
  input  port_e      last_grant,
  output port_e      grant
);

  always_comb begin
    if (req[1] && (!req[0] || last_grant == PORT_A)) grant = PORT_B;
    else                                             grant = PORT_A;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates two request ports onto one asynchronous SRAM, sequencing each
// access as SETUP, a STROBE_CYCLES-long strobe, then a one-cycle DONE/ack.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int STROBE_CYCLES = STROBE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              a_req,
  input  logic              b_req,
  input  logic              a_we,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_ack,
  output logic              b_ack,
  output logic [DATA_W-1:0] a_rdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              ram_en_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  state_e            state, state_nx;
  logic [3:0]        cnt;
  port_e             last_grant, gnt, rr_grant;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              start, strobe_end, drive;

  sram_arb_rr u_rr (
    .req        ({b_req, a_req}),
    .last_grant (last_grant),
    .grant      (rr_grant)
  );

  assign start      = en && (a_req || b_req);
  assign strobe_end = (cnt == 4'd0);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SETUP;
      SETUP:   state_nx = STROBE;
      STROBE:  if (strobe_end) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: rdata is reset along with the control state; these are plain
      // registers, not a memory array, so the reset costs nothing structural.
      state      <= IDLE;
      cnt        <= 4'd0;
      last_grant <= PORT_B;
      gnt        <= PORT_A;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      a_rdata    <= '0;
      b_rdata    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          gnt        <= rr_grant;
          last_grant <= rr_grant;
          lat_we     <= (rr_grant == PORT_A) ? a_we    : b_we;
          lat_addr   <= (rr_grant == PORT_A) ? a_addr  : b_addr;
          lat_wdata  <= (rr_grant == PORT_A) ? a_wdata : b_wdata;
        end
        SETUP: cnt <= 4'(STROBE_CYCLES - 1);
        STROBE: begin
          if (!strobe_end) cnt <= cnt - 4'd1;
          // The read sample is taken on the edge that closes the strobe.
          else if (!lat_we) begin
            if (gnt == PORT_A) a_rdata <= ram_data;
            else               b_rdata <= ram_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Write data stays on the bus through DONE to give the SRAM hold time.
  always_comb begin
    ram_en_n = 1'b1;
    ram_oe_n = 1'b1;
    ram_we_n = 1'b1;
    drive    = 1'b0;
    case (state)
      SETUP: begin
        ram_en_n = 1'b0;
        ram_oe_n = lat_we;
        drive    = lat_we;
      end
      STROBE: begin
        ram_en_n = 1'b0;
        ram_oe_n = lat_we;
        ram_we_n = !lat_we;
        drive    = lat_we;
      end
      DONE:    drive = lat_we;
      default: ;
    endcase
  end

  assign ram_data = drive ? lat_wdata : {DATA_W{1'bz}};
  assign ram_addr = lat_addr;
  assign busy     = (state != IDLE);
  assign a_ack    = (state == DONE) && (gnt == PORT_A);
  assign b_ack    = (state == DONE) && (gnt == PORT_B);

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed vector table, corner-case
// sequences, and a randomized run against a transaction-level model.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        a_req = 1'b0, b_req = 1'b0, a_we = 1'b0, b_we = 1'b0;
  logic [17:0] a_addr = '0, b_addr = '0;
  logic [15:0] a_wdata = '0, b_wdata = '0;
  logic        a_ack, b_ack, busy, ram_en_n, ram_oe_n, ram_we_n;
  logic [15:0] a_rdata, b_rdata;
  logic [17:0] ram_addr;
  wire  [15:0] ram_data;

  logic [15:0] sram [0:31];

  int n_pass = 0;
  int n_total = 0;

  sram_arbiter #(.STROBE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .en(en),
    .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_ack(a_ack), .b_ack(b_ack), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .busy(busy), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_en_n(ram_en_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  always #5 clk = ~clk;

  // Small SRAM model: drives on read enable, captures while write-enabled.
  assign ram_data = (!ram_en_n && !ram_oe_n) ? sram[ram_addr[4:0]] : 16'hzzzz;
  always @(posedge clk) if (!ram_en_n && !ram_we_n) sram[ram_addr[4:0]] <= ram_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        a_req, b_req, a_we, b_we;
    logic [17:0] addr;
    logic [15:0] wdata;
    port_e       exp_port;
    logic [15:0] exp_a_rd, exp_b_rd;
  } vec_t;

  vec_t vecs [8];

  // One access: request for one edge only, then scramble the inputs.
  task automatic run_vec(input vec_t v, input int idx);
    int   n, wen, oen, drv;
    logic got, is_wr;
    is_wr   = (v.exp_port == PORT_A) ? v.a_we : v.b_we;
    a_req   = v.a_req;  b_req   = v.b_req;
    a_we    = v.a_we;   b_we    = v.b_we;
    a_addr  = v.addr;   b_addr  = v.addr;
    a_wdata = v.wdata;  b_wdata = v.wdata;
    @(posedge clk); #1;
    a_req = 1'b0; b_req = 1'b0;
    a_we = ~v.a_we; b_we = ~v.b_we;
    a_addr = ~v.addr; b_addr = ~v.addr;
    a_wdata = ~v.wdata; b_wdata = ~v.wdata;
    n = 0; wen = 0; oen = 0; drv = 0; got = 1'b0;
    while (!got && n < 20) begin
      if (!ram_we_n) wen++;
      if (!ram_oe_n) oen++;
      if (ram_data === v.wdata) drv++;
      if (a_ack || b_ack) got = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    check($sformatf("v%0d_latency", idx), n, S + 1);
    check($sformatf("v%0d_port", idx), b_ack, v.exp_port == PORT_B);
    check($sformatf("v%0d_ack_onehot", idx), a_ack && b_ack, 0);
    if (is_wr) begin
      check($sformatf("v%0d_we_cycles", idx), wen, S);
      check($sformatf("v%0d_drive_cycles", idx), drv, S + 2);
    end else begin
      check($sformatf("v%0d_oe_cycles", idx), oen, S + 1);
    end
    check($sformatf("v%0d_a_rdata", idx), a_rdata, v.exp_a_rd);
    check($sformatf("v%0d_b_rdata", idx), b_rdata, v.exp_b_rd);
    @(posedge clk); #1;
    check($sformatf("v%0d_idle_after", idx), {busy, a_ack, b_ack}, 3'b000);
  endtask

  initial begin
    int   n, acks, prev, cyc, nb;
    port_e exp_p;
    int   free_edge, busy_end, ack_edge;
    logic pend, m_we, g_we;
    port_e m_last, m_port;
    logic [15:0] m_val, m_rd_a, m_rd_b, g_wd;
    logic [17:0] g_addr;
    logic [15:0] ref_mem [0:31];

    for (int i = 0; i < 32; i++) sram[i] = 16'h0000;

    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 18'h00010, 16'h1234, PORT_A, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 18'h00010, 16'h0000, PORT_B, 16'h0000, 16'h1234};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 18'h00011, 16'hBEEF, PORT_A, 16'h0000, 16'h1234};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 18'h00011, 16'h0000, PORT_B, 16'h0000, 16'hBEEF};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 18'h00010, 16'h0000, PORT_A, 16'h1234, 16'hBEEF};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 18'h00010, 16'h0000, PORT_B, 16'h1234, 16'h1234};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 18'h00010, 16'h5555, PORT_B, 16'h1234, 16'h1234};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 18'h00010, 16'h0000, PORT_A, 16'h5555, 16'h1234};

    // Reset state.
    #1 rst = 1'b0;
    #2;
    check("rst_strobes", {ram_en_n, ram_oe_n, ram_we_n}, 3'b111);
    check("rst_bus_z", ram_data === 16'hzzzz, 1);
    check("rst_addr", ram_addr, 0);
    check("rst_acks_busy", {a_ack, b_ack, busy}, 3'b000);
    check("rst_rdata", {a_rdata, b_rdata}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Both ports held high: strict alternation, one ack every S+3 cycles.
    exp_p = PORT_B; prev = -1; acks = 0; cyc = 0;
    a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0;
    a_addr = 18'h00010; b_addr = 18'h00010;
    while (acks < 4 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (a_ack || b_ack) begin
        check("tie_port", b_ack, exp_p == PORT_B);
        if (prev >= 0) check("tie_spacing", cyc - prev, S + 3);
        prev = cyc;
        acks++;
        exp_p = (exp_p == PORT_A) ? PORT_B : PORT_A;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    check("tie_count", acks, 4);
    @(posedge clk); #1;

    // Grant enable low blocks new grants.
    en = 1'b0; a_req = 1'b1; nb = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (busy || !ram_en_n) nb++;
    end
    check("en_low_no_grant", nb, 0);
    en = 1'b1;
    @(posedge clk); #1;
    check("en_high_setup", {busy, ram_en_n}, 2'b10);
    a_req = 1'b0; n = 0;
    while (!a_ack && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("en_ack_latency", n, S + 1);
    @(posedge clk); #1;

    // Reset in the middle of a write strobe.
    a_req = 1'b1; a_we = 1'b1; a_addr = 18'h00012; a_wdata = 16'hA5A5;
    @(posedge clk); #1;
    a_req = 1'b0;
    @(posedge clk); #1;
    check("mid_we_low", ram_we_n, 0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_strobes", {ram_en_n, ram_oe_n, ram_we_n}, 3'b111);
    check("mid_rst_bus_z", ram_data === 16'hzzzz, 1);
    check("mid_rst_busy_addr", {busy, ram_addr}, 0);
    check("mid_rst_rdata", {a_rdata, b_rdata}, 0);
    @(negedge clk) rst = 1'b1;
    nb = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (a_ack || b_ack || busy) nb++;
    end
    check("mid_rst_no_ack", nb, 0);
    a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0; a_addr = 18'h00010; b_addr = 18'h00010;
    @(posedge clk); #1;
    a_req = 1'b0; b_req = 1'b0; n = 0;
    while (!(a_ack || b_ack) && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("post_rst_tie_a", {a_ack, b_ack}, 2'b10);
    check("post_rst_a_rdata", a_rdata, 16'h5555);
    @(posedge clk); #1;

    // Randomized run against a transaction-level model.
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      sram[i]    = 16'h0000;
      ref_mem[i] = 16'h0000;
    end
    @(negedge clk) rst = 1'b1;
    m_last = PORT_B; m_port = PORT_A; free_edge = 0; busy_end = 0; ack_edge = -1;
    pend = 1'b0; m_we = 1'b0; m_val = '0; m_rd_a = '0; m_rd_b = '0;
    for (int i = 0; i < 400; i++) begin
      en      = ($urandom_range(0, 7) != 0);
      a_req   = ($urandom_range(0, 2) == 0);
      b_req   = ($urandom_range(0, 2) == 0);
      a_we    = $urandom_range(0, 1) == 1;
      b_we    = $urandom_range(0, 1) == 1;
      a_addr  = 18'($urandom_range(0, 31));
      b_addr  = 18'($urandom_range(0, 31));
      a_wdata = 16'($urandom);
      b_wdata = 16'($urandom);
      @(posedge clk);
      if (i >= free_edge && en && (a_req || b_req)) begin
        if (a_req && b_req) m_port = (m_last == PORT_A) ? PORT_B : PORT_A;
        else                m_port = a_req ? PORT_A : PORT_B;
        m_last = m_port;
        g_we   = (m_port == PORT_A) ? a_we : b_we;
        g_addr = (m_port == PORT_A) ? a_addr : b_addr;
        g_wd   = (m_port == PORT_A) ? a_wdata : b_wdata;
        if (g_we) ref_mem[g_addr[4:0]] = g_wd;
        else      m_val = ref_mem[g_addr[4:0]];
        m_we = g_we; pend = 1'b1;
        ack_edge = i + S + 1; busy_end = i + S + 2; free_edge = i + S + 3;
      end
      if (pend && i == ack_edge && !m_we) begin
        if (m_port == PORT_A) m_rd_a = m_val;
        else                  m_rd_b = m_val;
      end
      #1;
      check("rnd_a_ack", a_ack, pend && i == ack_edge && m_port == PORT_A);
      check("rnd_b_ack", b_ack, pend && i == ack_edge && m_port == PORT_B);
      check("rnd_busy", busy, i < busy_end);
      check("rnd_a_rdata", a_rdata, m_rd_a);
      check("rnd_b_rdata", b_rdata, m_rd_b);
      if (!ram_oe_n) check("rnd_bus_clean", $isunknown(ram_data), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
